// File: rtl/fp32_pkg.sv
// Shared FP32 constants and the multiplier FSM state type.
package fp32_pkg;

    localparam int EXP_WIDTH = 8;
    localparam int MAN_WIDTH = 23;
    localparam int BIAS = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF_POS = 32'h7F80_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_NORM  = 2'd2,
        S_ROUND = 2'd3
    } state_t;

endpackage

// File: rtl/fp32_round.sv
// Round-to-nearest-even on a normalized 24-bit significand, then pack
// the result with overflow to infinity and underflow flushed to zero.
module fp32_round
    import fp32_pkg::*;
(
    input  logic                 sign_i,
    input  logic [9:0]           exp_i,
    input  logic [MAN_WIDTH:0]   sig_i,
    input  logic                 guard_i,
    input  logic                 rnd_i,
    input  logic                 sticky_i,
    output logic [31:0]          res_o
);

    logic                 inc;
    logic [MAN_WIDTH+1:0] sum;
    logic [MAN_WIDTH-1:0] man;
    logic [9:0]           exp_r;

    always_comb begin
        inc = guard_i & (rnd_i | sticky_i | sig_i[0]);
        sum = {1'b0, sig_i} + {{(MAN_WIDTH+1){1'b0}}, inc};
        // Carry out of the significand means 1.111.. rounded up to 10.000..
        man = sum[MAN_WIDTH+1] ? sum[MAN_WIDTH:1] : sum[MAN_WIDTH-1:0];
        exp_r = exp_i + {9'd0, sum[MAN_WIDTH+1]};
        if ($signed(exp_r) >= 10'sd255) begin
            res_o = {sign_i, INF_POS[30:0]};
        end else if ($signed(exp_r) <= 10'sd0) begin
            res_o = {sign_i, 31'd0};
        end else begin
            res_o = {sign_i, exp_r[EXP_WIDTH-1:0], man};
        end
    end

endmodule

// File: rtl/float_mul_seq.sv
// Sequential FP32 multiplier: 24-step shift-add significand product,
// one normalize cycle and one round cycle, fixed 26-edge latency.
module float_mul_seq
    import fp32_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  busy,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] C
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("float_mul_seq supports only DATA_WIDTH=32");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [47:0] acc_q, acc_d;
    logic [47:0] ma_q, ma_d;
    logic [23:0] mb_q, mb_d;
    logic [9:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_val_q, spec_val_d;
    logic [23:0] sig_q, sig_d;
    logic        g_q, g_d;
    logic        r_q, r_d;
    logic        s_q, s_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic [31:0] c_q, c_d;

    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        sgn;
    logic [31:0] rnd_res;

    always_comb begin
        sgn = A[31] ^ B[31];
        // Denormal inputs fall into the zero class.
        a_zero = (A[30:23] == 8'd0);
        b_zero = (B[30:23] == 8'd0);
        a_inf = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
        b_inf = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
        a_nan = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
        b_nan = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        ma_d = ma_q;
        mb_d = mb_q;
        exp_d = exp_q;
        sign_d = sign_q;
        spec_d = spec_q;
        spec_val_d = spec_val_q;
        sig_d = sig_q;
        g_d = g_q;
        r_d = r_q;
        s_d = s_q;
        busy_d = busy_q;
        ack_d = 1'b0;
        c_d = c_q;
        unique case (state_q)
            S_IDLE: begin
                if (enb) begin
                    sign_d = sgn;
                    ma_d = {24'd0, ~a_zero, A[22:0]};
                    mb_d = {~b_zero, B[22:0]};
                    exp_d = {2'b00, A[30:23]} + {2'b00, B[30:23]}
                          - 10'(BIAS);
                    acc_d = 48'd0;
                    cnt_d = 5'd0;
                    spec_d = a_nan | b_nan | a_inf | b_inf
                           | a_zero | b_zero;
                    if (a_nan || b_nan || (a_inf && b_zero)
                        || (b_inf && a_zero)) begin
                        spec_val_d = QNAN;
                    end else if (a_inf || b_inf) begin
                        spec_val_d = {sgn, INF_POS[30:0]};
                    end else begin
                        spec_val_d = {sgn, 31'd0};
                    end
                    busy_d = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mb_q[0]) begin
                    acc_d = acc_q + ma_q;
                end
                ma_d = ma_q << 1;
                mb_d = mb_q >> 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (acc_q[47]) begin
                    sig_d = acc_q[47:24];
                    g_d = acc_q[23];
                    r_d = acc_q[22];
                    s_d = |acc_q[21:0];
                    exp_d = exp_q + 10'd1;
                end else begin
                    sig_d = acc_q[46:23];
                    g_d = acc_q[22];
                    r_d = acc_q[21];
                    s_d = |acc_q[20:0];
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                c_d = spec_q ? spec_val_q : rnd_res;
                ack_d = 1'b1;
                busy_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    fp32_round u_round (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .sig_i    (sig_q),
        .guard_i  (g_q),
        .rnd_i    (r_q),
        .sticky_i (s_q),
        .res_o    (rnd_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q <= 5'd0;
            acc_q <= 48'd0;
            ma_q <= 48'd0;
            mb_q <= 24'd0;
            exp_q <= 10'd0;
            sign_q <= 1'b0;
            spec_q <= 1'b0;
            spec_val_q <= 32'd0;
            sig_q <= 24'd0;
            g_q <= 1'b0;
            r_q <= 1'b0;
            s_q <= 1'b0;
            busy_q <= 1'b0;
            ack_q <= 1'b0;
            c_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            ma_q <= ma_d;
            mb_q <= mb_d;
            exp_q <= exp_d;
            sign_q <= sign_d;
            spec_q <= spec_d;
            spec_val_q <= spec_val_d;
            sig_q <= sig_d;
            g_q <= g_d;
            r_q <= r_d;
            s_q <= s_d;
            busy_q <= busy_d;
            ack_q <= ack_d;
            c_q <= c_d;
        end
    end

    assign busy = busy_q;
    assign ack = ack_q;
    assign C = c_q;

endmodule
